deco_ins_q: RTL and testbench

DECO_INS_Q -- requirements
Module: deco_ins_q

---
 rtl/deco_ins_q_if.sv | 44 ++++
 rtl/deco_ins_q.sv | 125 ++++++++++++
 tb/tb_deco_ins_q.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/deco_ins_q_if.sv
// deco_ins_q_if -- handshake bundle for the deco_ins_q instruction queue.
//
// Valid/ready semantics, both sides: a transfer happens on a rising clock edge
// where valid and ready are both 1. Valid, once raised, must not depend on
// ready. The producer side is RI_i/ri_valid_i/ri_ready_o. The consumer side is
// DI_o/ill_o/di_valid_o/di_ready_i.
//
// Signals:
//   RI_i        opcode offered to the queue
//   ri_valid_i  RI_i is valid
//   ri_ready_o  queue can accept an opcode this cycle
//   flush_i     synchronous clear of the queue and the output stage
//   DI_o        registered one-hot decode; bit k means opcode k
//   di_valid_o  DI_o/ill_o hold a decoded instruction
//   di_ready_i  consumer takes the output this cycle
//   ill_o       presented opcode is outside the decoded range
//   cnt_o       number of opcodes queued, not counting the output stage
//
// Modports: slave = queue side, master = producer/consumer side.
interface deco_ins_q_if #(
  parameter int OPW   = 4,
  parameter int NOPS  = 8,
  parameter int DEPTH = 4
);
  logic [OPW-1:0]               RI_i;
  logic                         ri_valid_i;
  logic                         ri_ready_o;
  logic                         flush_i;
  logic [0:NOPS-1]              DI_o;
  logic                         di_valid_o;
  logic                         di_ready_i;
  logic                         ill_o;
  logic [$clog2(DEPTH+1)-1:0]   cnt_o;

  modport slave (
    input  RI_i, ri_valid_i, flush_i, di_ready_i,
    output ri_ready_o, DI_o, di_valid_o, ill_o, cnt_o
  );

  modport master (
    output RI_i, ri_valid_i, flush_i, di_ready_i,
    input  ri_ready_o, DI_o, di_valid_o, ill_o, cnt_o
  );
endinterface

// File: rtl/deco_ins_q.sv
// deco_ins_q -- instruction FIFO followed by a registered one-hot decode stage.
//
// Opcodes enter through RI_i/ri_valid_i/ri_ready_o and are stored in a
// DEPTH-entry circular buffer. Whenever the output stage is empty or is being
// consumed, the oldest opcode is popped and decoded into DI_o (one-hot, bit k
// for opcode k). Opcodes >= NOPS are still delivered, with DI_o = 0 and
// ill_o = 1.
//
// Ports:
//   clk_i   clock, all state changes on its rising edge
//   rstn_i  asynchronous active-low reset
//   bus     deco_ins_q_if.slave handshake bundle (see the interface file)
module deco_ins_q #(
  parameter int OPW   = 4,
  parameter int NOPS  = 8,
  parameter int DEPTH = 4
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  deco_ins_q_if.slave    bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [OPW-1:0]  mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;

  logic [0:NOPS-1] di_q;
  logic            di_valid_q;
  logic            ill_q;

  logic            full;
  logic            empty;
  logic            out_free;
  logic            push;
  logic            pop;

  logic [OPW-1:0]  head;
  logic            head_ill;
  logic [0:NOPS-1] head_dec;

  // Ready depends only on occupancy, so a pop in the same cycle never lets a
  // full queue accept another opcode.
  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign out_free = !di_valid_q || bus.di_ready_i;
  assign push     = bus.ri_valid_i && !full;
  assign pop      = !empty && out_free;

  assign head = mem[rd_ptr];

  // Zero-extend by one bit so NOPS == 2**OPW compares correctly.
  always_comb begin
    head_dec = '0;
    head_ill = ({1'b0, head} >= (OPW+1)'(NOPS));
    for (int k = 0; k < NOPS; k++) begin
      head_dec[k] = (head == OPW'(k));
    end
  end

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage carries no reset: entries are only read once the pointers say
  // they hold data.
  always_ff @(posedge clk_i) begin
    if (push && !bus.flush_i) begin
      mem[wr_ptr] <= bus.RI_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      di_q       <= '0;
      di_valid_q <= 1'b0;
      ill_q      <= 1'b0;
    end else if (bus.flush_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      di_q       <= '0;
      di_valid_q <= 1'b0;
      ill_q      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      // Output stage: load the head, clear when nothing is left, otherwise
      // hold while the consumer stalls.
      if (out_free) begin
        if (!empty) begin
          di_q       <= head_dec;
          ill_q      <= head_ill;
          di_valid_q <= 1'b1;
        end else begin
          di_q       <= '0;
          ill_q      <= 1'b0;
          di_valid_q <= 1'b0;
        end
      end
    end
  end

  assign bus.ri_ready_o = !full;
  assign bus.DI_o       = di_q;
  assign bus.di_valid_o = di_valid_q;
  assign bus.ill_o      = ill_q;
  assign bus.cnt_o      = cnt;

endmodule

// File: tb/tb_deco_ins_q.sv
// tb_deco_ins_q -- bench for deco_ins_q: directed scenarios plus a random
// phase, with a scoreboard queue holding the expected {ill, DI} of every
// opcode accepted and not yet consumed (the presented one sits at the front).
module tb_deco_ins_q;
  localparam int OPW   = 4;
  localparam int NOPS  = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk;
  logic rstn;

  deco_ins_q_if #(.OPW(OPW), .NOPS(NOPS), .DEPTH(DEPTH)) bus ();

  deco_ins_q #(.OPW(OPW), .NOPS(NOPS), .DEPTH(DEPTH)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [NOPS:0] exp_q[$];
  logic [NOPS-1:0] di_flat;
  assign di_flat = bus.DI_o;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Expected {ill, DI} with DI in declared order (DI[0] leftmost).
  function automatic logic [NOPS:0] exp_of(input int v);
    logic [NOPS:0] r;
    r = '0;
    if (v < NOPS) r[NOPS-1-v] = 1'b1;
    else          r[NOPS]     = 1'b1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    bus.ri_valid_i = 1'b0;
    repeat (n) step();
  endtask

  task automatic push_op(input int v);
    bit acc;
    int n;
    bus.RI_i       = OPW'(v);
    bus.ri_valid_i = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = bus.ri_ready_o;
      step();
      n++;
    end
    bus.ri_valid_i = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: opcode %0d not accepted within 20 cycles, required acceptance", v);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rstn) begin
      chk("occupancy", 64'(int'(bus.cnt_o) + int'(bus.di_valid_o)), 64'(exp_q.size()));
      chk("ready_vs_cnt", 64'(bus.ri_ready_o), 64'(int'(bus.cnt_o) < DEPTH));
      if (bus.di_valid_o) begin
        chk("output_has_source", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0)
          chk("output_data", 64'({bus.ill_o, di_flat}), 64'(exp_q[0]));
      end else begin
        chk("idle_output_zero", 64'({bus.ill_o, di_flat}), 64'(0));
      end
      if (bus.flush_i) begin
        exp_q.delete();
      end else begin
        if (bus.di_valid_o && bus.di_ready_i && exp_q.size() > 0) void'(exp_q.pop_front());
        if (bus.ri_valid_i && bus.ri_ready_o) exp_q.push_back(exp_of(int'(bus.RI_i)));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rstn           = 1'b0;
    bus.RI_i       = '0;
    bus.ri_valid_i = 1'b0;
    bus.flush_i    = 1'b0;
    bus.di_ready_i = 1'b1;
    #13;
    chk("reset_cnt",   64'(bus.cnt_o), 64'(0));
    chk("reset_valid", 64'(bus.di_valid_o), 64'(0));
    chk("reset_di",    64'({bus.ill_o, di_flat}), 64'(0));
    chk("reset_ready", 64'(bus.ri_ready_o), 64'(1));
    @(negedge clk);
    rstn = 1'b1;
    step();

    // Latency from an empty queue and idle output stage.
    bus.di_ready_i = 1'b1;
    push_op(0);
    chk("lat_cnt_after_push", 64'(bus.cnt_o), 64'(1));
    chk("lat_not_yet_valid",  64'(bus.di_valid_o), 64'(0));
    step();
    chk("lat_valid", 64'(bus.di_valid_o), 64'(1));
    chk("lat_di",    64'(di_flat), 64'(8'b1000_0000));
    chk("lat_ill",   64'(bus.ill_o), 64'(0));
    idle(3);

    // Stalled consumer fills the queue.
    bus.di_ready_i = 1'b0;
    for (int v = 3; v <= 7; v++) push_op(v);
    chk("full_cnt",   64'(bus.cnt_o), 64'(DEPTH));
    chk("full_ready", 64'(bus.ri_ready_o), 64'(0));
    chk("full_hold_di", 64'(di_flat), 64'(8'b0001_0000));
    bus.RI_i       = '0;
    bus.ri_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full_no_push", 64'(bus.cnt_o), 64'(DEPTH));
      chk("full_hold_di", 64'(di_flat), 64'(8'b0001_0000));
    end
    bus.ri_valid_i = 1'b0;
    bus.di_ready_i = 1'b1;
    idle(8);

    // Illegal opcodes are delivered with ill set.
    push_op(15);
    push_op(8);
    chk("ill_first_di",    64'(di_flat), 64'(0));
    chk("ill_first_flag",  64'(bus.ill_o), 64'(1));
    chk("ill_first_valid", 64'(bus.di_valid_o), 64'(1));
    step();
    chk("ill_second_di",   64'(di_flat), 64'(0));
    chk("ill_second_flag", 64'(bus.ill_o), 64'(1));
    idle(4);

    // Flush overrides a simultaneous push.
    bus.di_ready_i = 1'b0;
    for (int v = 1; v <= 4; v++) push_op(v);
    chk("pre_flush_cnt", 64'(bus.cnt_o), 64'(3));
    bus.flush_i    = 1'b1;
    bus.RI_i       = OPW'(5);
    bus.ri_valid_i = 1'b1;
    step();
    bus.flush_i    = 1'b0;
    bus.ri_valid_i = 1'b0;
    chk("flush_cnt",   64'(bus.cnt_o), 64'(0));
    chk("flush_valid", 64'(bus.di_valid_o), 64'(0));
    chk("flush_di",    64'({bus.ill_o, di_flat}), 64'(0));
    bus.di_ready_i = 1'b1;
    idle(4);

    // Streaming across pointer wrap.
    for (int i = 0; i < 12; i++) begin
      push_op(i % 8);
      if (i >= 1) begin
        chk("stream_cnt", 64'(bus.cnt_o), 64'(1));
        chk("stream_di",  64'(di_flat), 64'(exp_of((i - 1) % 8)));
      end
    end
    idle(4);

    // Asynchronous reset pulse between edges.
    bus.di_ready_i = 1'b0;
    for (int v = 1; v <= 3; v++) push_op(v);
    chk("pre_reset_cnt", 64'(bus.cnt_o), 64'(2));
    #1;
    rstn = 1'b0;
    exp_q.delete();
    #1;
    chk("areset_cnt",   64'(bus.cnt_o), 64'(0));
    chk("areset_valid", 64'(bus.di_valid_o), 64'(0));
    chk("areset_di",    64'({bus.ill_o, di_flat}), 64'(0));
    chk("areset_ready", 64'(bus.ri_ready_o), 64'(1));
    #1;
    rstn = 1'b1;
    bus.di_ready_i = 1'b1;
    idle(5);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bus.ri_valid_i = ($urandom_range(0, 9) < 7);
      bus.RI_i       = OPW'($urandom_range(0, 15));
      bus.di_ready_i = ($urandom_range(0, 3) != 0);
      bus.flush_i    = ($urandom_range(0, 49) == 0);
      step();
    end
    bus.flush_i    = 1'b0;
    bus.di_ready_i = 1'b1;
    idle(10);
    chk("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
